// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
// Binary-search initiator for a magnitude comparator. A candidate value is
// driven on guess, and the comparator's lt/gt/eq flags narrow the [lo, hi]
// range by one probe per clock until equality is reported. The search stops
// with an error pulse if the flags are inconsistent or the range runs out.
//
// Ports:
//   clk          rising-edge system clock
//   reset_p      synchronous active-high reset
//   start        one-cycle search request, sampled only in IDLE
//   lt, gt, eq   comparator flags for guess versus the hidden target
//   guess        registered candidate value driven to the comparator
//   busy         high while a search is in progress (PROBE)
//   done         one-cycle pulse when the target has been found
//   error        one-cycle pulse on bad flags or an exhausted range
//   found_value  last matched value, held until the next successful search
//   probe_count  probes used by the current or last search
module sar_search_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] found_value,
  output logic [CNT_W-1:0] probe_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] found_q, found_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  // Bounds chosen for the next probe, and their midpoint sum kept one bit wider
  // than the operands so lo+hi never wraps.
  logic [WIDTH-1:0] lo_n_s;
  logic [WIDTH-1:0] hi_n_s;
  logic [WIDTH:0]   sum_s;
  logic             fail_s;

  assign guess       = guess_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign found_value = found_q;
  assign probe_count = cnt_q;

  // Next-state and output computation for the IDLE/PROBE search controller.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    found_d = found_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    lo_n_s  = lo_q;
    hi_n_s  = hi_q;
    sum_s   = {(WIDTH+1){1'b0}};
    fail_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_n_s  = MIN_V;
          hi_n_s  = MAX_V;
          sum_s   = {1'b0, lo_n_s} + {1'b0, hi_n_s};
          lo_d    = lo_n_s;
          hi_d    = hi_n_s;
          guess_d = sum_s[WIDTH:1];
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
          state_d = PROBE;
        end else begin
          busy_d  = 1'b0;
        end
      end

      PROBE: begin
        if (eq && !lt && !gt) begin
          found_d = guess_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // Target above guess: nothing left above guess means the range is
          // exhausted (guess == hi also covers guess == max value).
          if (lt && !gt && !eq) begin
            if ((guess_q == MAX_V) || (guess_q == hi_q)) begin
              fail_s = 1'b1;
            end else begin
              lo_n_s = guess_q + ONE_V;
            end
          end else if (gt && !lt && !eq) begin
            if ((guess_q == MIN_V) || (guess_q == lo_q)) begin
              fail_s = 1'b1;
            end else begin
              hi_n_s = guess_q - ONE_V;
            end
          end else begin
            // No flag, or more than one flag, cannot come from a comparator.
            fail_s = 1'b1;
          end

          if (fail_s) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            sum_s   = {1'b0, lo_n_s} + {1'b0, hi_n_s};
            lo_d    = lo_n_s;
            hi_d    = hi_n_s;
            guess_d = sum_s[WIDTH:1];
            cnt_d   = cnt_q + CNT_ONE;
            busy_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= IDLE;
      lo_q    <= MIN_V;
      hi_q    <= MAX_V;
      guess_q <= MIN_V;
      found_q <= MIN_V;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule
